// File: rtl/half_sub_pkg.sv
// Shared constants and types for the half_subtractor slice.
// The borrow counter types are only consumed when HALF_SUB_BORROW_CNT_EN is defined.
package half_sub_pkg;

    localparam int HS_CNT_W = 16;
    localparam logic [HS_CNT_W-1:0] HS_CNT_MAX = 16'hFFFF;

    typedef logic [HS_CNT_W-1:0] hs_cnt_t;

    // Saturating increment: holds at HS_CNT_MAX instead of wrapping to zero.
    function automatic hs_cnt_t hs_sat_inc(input hs_cnt_t cnt);
        if (cnt == HS_CNT_MAX) begin
            return cnt;
        end
        return cnt + hs_cnt_t'(1);
    endfunction

endpackage

// File: rtl/half_subtractor_hs_cell.sv
// 1-bit half subtractor cell: d = x - y (mod 2), bo = borrow out.
// Two of these plus an OR form one ripple full-subtract stage.
module hs_cell (
    input  logic x,
    input  logic y,
    output logic d,
    output logic bo
);

    assign d  = x ^ y;
    assign bo = ~x & y;

endmodule

// File: rtl/half_subtractor.sv
// WIDTH-bit ripple subtractor with combinational outputs and a 1-cycle registered copy.
// Define HALF_SUB_BORROW_CNT_EN to add the saturating borrow_cnt output.
module half_subtractor
    import half_sub_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] difference,
    output logic             borrow,
    output logic             out_valid,
    output logic [WIDTH-1:0] diff_q,
    output logic             borrow_q
`ifdef HALF_SUB_BORROW_CNT_EN
    ,
    output logic [HS_CNT_W-1:0] borrow_cnt
`endif
);

    // Handshake: valid-only, no backpressure. A beat is taken on every rising
    // edge where in_valid=1; out_valid=1 for exactly the cycle after that edge.

    logic [WIDTH-1:0] brw_chain;

    genvar i;
    generate
        for (i = 0; i < WIDTH; i++) begin : g_stage
            if (i == 0) begin : g_lsb
                hs_cell u_cell (
                    .x  (a[0]),
                    .y  (b[0]),
                    .d  (difference[0]),
                    .bo (brw_chain[0])
                );
            end else begin : g_ripple
                logic d_ab;
                logic bo_ab;
                logic bo_in;

                hs_cell u_cell_ab (
                    .x  (a[i]),
                    .y  (b[i]),
                    .d  (d_ab),
                    .bo (bo_ab)
                );

                // Second cell subtracts the borrow rippling in from the bit below.
                hs_cell u_cell_bin (
                    .x  (d_ab),
                    .y  (brw_chain[i-1]),
                    .d  (difference[i]),
                    .bo (bo_in)
                );

                assign brw_chain[i] = bo_ab | bo_in;
            end
        end
    endgenerate

    assign borrow = brw_chain[WIDTH-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            diff_q    <= '0;
            borrow_q  <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                diff_q   <= difference;
                borrow_q <= borrow;
            end
        end
    end

`ifdef HALF_SUB_BORROW_CNT_EN
    hs_cnt_t cnt_r;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= '0;
        end else if (in_valid && borrow) begin
            cnt_r <= hs_sat_inc(cnt_r);
        end
    end

    assign borrow_cnt = cnt_r;
`endif

endmodule

// File: tb/tb_half_subtractor.sv
// Self-checking bench for half_subtractor at WIDTH=1, 8 and 16.
// Define HALF_SUB_BORROW_CNT_EN at compile time to also exercise borrow_cnt.
module tb_half_subtractor;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // ---------------- DUT signals ----------------
    logic        iv1, a1, b1, d1, bo1, ov1, dq1, bq1;
    logic        iv8, bo8, ov8, bq8;
    logic [7:0]  a8, b8, d8, dq8;
    logic        iv16, bo16, ov16, bq16;
    logic [15:0] a16, b16, d16, dq16;
`ifdef HALF_SUB_BORROW_CNT_EN
    logic [15:0] cnt1, cnt8, cnt16;
`endif

    half_subtractor #(.WIDTH(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv1), .a(a1), .b(b1),
        .difference(d1), .borrow(bo1), .out_valid(ov1), .diff_q(dq1), .borrow_q(bq1)
`ifdef HALF_SUB_BORROW_CNT_EN
        , .borrow_cnt(cnt1)
`endif
    );

    half_subtractor #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv8), .a(a8), .b(b8),
        .difference(d8), .borrow(bo8), .out_valid(ov8), .diff_q(dq8), .borrow_q(bq8)
`ifdef HALF_SUB_BORROW_CNT_EN
        , .borrow_cnt(cnt8)
`endif
    );

    half_subtractor #(.WIDTH(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv16), .a(a16), .b(b16),
        .difference(d16), .borrow(bo16), .out_valid(ov16), .diff_q(dq16), .borrow_q(bq16)
`ifdef HALF_SUB_BORROW_CNT_EN
        , .borrow_cnt(cnt16)
`endif
    );

    // ---------------- checker ----------------
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
            $error("%s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive1(input logic iv, input logic a, input logic b);
        iv1 = iv; a1 = a; b1 = b;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: unsigned subtraction with plain integer arithmetic.
    function automatic logic [16:0] ref_sub16(input logic [15:0] a, input logic [15:0] b);
        int unsigned r;
        r = (int'(a) - int'(b)) & 32'hFFFF;
        return {(a < b) ? 1'b1 : 1'b0, r[15:0]};
    endfunction

    // ---------------- scoreboard for the registered WIDTH=16 path ----------------
    logic [16:0] exp_q[$];
    logic [16:0] last_cap;

    initial begin
        logic [16:0] exp;
        logic [16:0] got;
        logic        iv;

        iv1 = 0; a1 = 0; b1 = 0;
        iv8 = 0; a8 = 0; b8 = 0;
        iv16 = 0; a16 = 0; b16 = 0;
        last_cap = '0;

        // Combinational truth table while reset is held (no clock dependency).
        drive1(0, 0, 0); #5; check("w1_00_d", d1, 0); check("w1_00_b", bo1, 0);
        drive1(0, 0, 1); #5; check("w1_01_d", d1, 1); check("w1_01_b", bo1, 1);
        drive1(0, 1, 0); #5; check("w1_10_d", d1, 1); check("w1_10_b", bo1, 0);
        drive1(0, 1, 1); #5; check("w1_11_d", d1, 0); check("w1_11_b", bo1, 0);

        check("rst_ov", ov1, 0);
        check("rst_dq", dq1, 0);
        check("rst_bq", bq1, 0);
`ifdef HALF_SUB_BORROW_CNT_EN
        check("rst_cnt", cnt1, 0);
`endif

        // Release reset away from the clock edge, then one capture.
        @(negedge clk); rst_n = 1;
        drive1(1, 0, 1);
        tick();
        check("cap_dq", dq1, 1);
        check("cap_bq", bq1, 1);
        check("cap_ov", ov1, 1);

        // in_valid low: registers hold despite new operands.
        @(negedge clk); drive1(0, 1, 1);
        tick();
        check("hold_ov", ov1, 0);
        check("hold_dq", dq1, 1);
        check("hold_bq", bq1, 1);

        // Capture again, then assert reset mid-cycle.
        @(negedge clk); drive1(1, 0, 1);
        tick();
        check("cap2_ov", ov1, 1);
        #2; rst_n = 0; #1;
        check("async_ov", ov1, 0);
        check("async_dq", dq1, 0);
        check("async_bq", bq1, 0);
        drive1(1, 1, 0); #1;
        check("rst_track_d", d1, 1);
        check("rst_track_b", bo1, 0);
        tick();
        check("rst_hold_ov", ov1, 0);
        @(negedge clk); rst_n = 1;
        drive1(0, 0, 0);

        // WIDTH=8 boundary vectors.
        a8 = 8'h00; b8 = 8'h01; #1; check("w8_wrap_d", d8, 8'hFF); check("w8_wrap_b", bo8, 1);
        a8 = 8'h80; b8 = 8'h80; #1; check("w8_eq_d", d8, 8'h00);   check("w8_eq_b", bo8, 0);
        a8 = 8'hFF; b8 = 8'h01; #1; check("w8_ff_d", d8, 8'hFE);   check("w8_ff_b", bo8, 0);
        a8 = 8'h00; b8 = 8'hFF; #1; check("w8_max_d", d8, 8'h01);  check("w8_max_b", bo8, 1);

        // Random WIDTH=16 vectors against the reference model and scoreboard.
        for (int n = 0; n < 1000; n++) begin
            @(negedge clk);
            a16 = 16'($urandom);
            b16 = 16'($urandom);
            if (n % 50 == 0) b16 = a16;
            iv = ($urandom_range(0, 3) != 0);
            iv16 = iv;
            #1;
            exp = ref_sub16(a16, b16);
            check("r16_d", d16, exp[15:0]);
            check("r16_b", bo16, exp[16]);
            if (iv) exp_q.push_back(exp);
            tick();
            check("r16_ov", ov16, iv);
            if (iv) begin
                if (exp_q.size() > 0) last_cap = exp_q.pop_front();
            end
            got = {bq16, dq16};
            check("r16_q", got, last_cap);
        end
        @(negedge clk); iv16 = 0;

`ifdef HALF_SUB_BORROW_CNT_EN
        // Counter: fresh reset, 3 borrows, non-borrows, then saturation.
        @(negedge clk); rst_n = 0;
        @(negedge clk); rst_n = 1;
        check("cnt_rst", cnt1, 0);
        drive1(1, 0, 1);
        repeat (3) @(negedge clk);
        check("cnt_3", cnt1, 3);
        drive1(1, 1, 0);
        repeat (3) @(negedge clk);
        check("cnt_noborrow", cnt1, 3);
        drive1(1, 0, 1);
        repeat (65531) @(negedge clk);
        check("cnt_fffe", cnt1, 16'hFFFE);
        repeat (3) @(negedge clk);
        check("cnt_sat", cnt1, 16'hFFFF);
        drive1(0, 0, 0);
`endif

        // ---------------- final report ----------------
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
